// File: rtl/fifo_uart_tx.sv
// Purpose : drains bytes from a show-ahead-off FIFO and serialises them as 8N1/8N2 UART frames.
// Latency : start bit begins 2 cycles after the IDLE cycle that issues fifo_rdreq.
// Backpressure: only pops when tx_en=1 and fifo_empty=0; the FIFO absorbs all stalls.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-low reset
//   fifo_q     FIFO read data, valid the cycle after fifo_rdreq
//   fifo_empty FIFO empty flag
//   fifo_rdreq one-cycle FIFO pop, issued from IDLE only
//   tx_en      gates the start of new frames; never aborts a frame in flight
//   txd        registered serial line, idle high
//   busy       registered, high from FETCH through the last stop-bit cycle
//   tx_done    registered one-cycle pulse after the final stop bit
//
// Optional feature: define FIFO_UART_TX_PARITY_EN to insert an even parity bit after
// the data bits. Without it the frame is start + 8 data + STOP_BITS stop bits.

module fifo_uart_tx #(
  parameter int unsigned CLK_DIV   = 434,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] fifo_q,
  input  logic       fifo_empty,
  output logic       fifo_rdreq,
  input  logic       tx_en,
  output logic       txd,
  output logic       busy,
  output logic       tx_done
);

  // Bit-period down-counter reload: each bit lasts RELOAD+1 = CLK_DIV cycles.
  localparam logic [15:0] RELOAD = 16'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_START  = 3'd2,
    S_DATA   = 3'd3,
`ifdef FIFO_UART_TX_PARITY_EN
    S_PARITY = 3'd4,
`endif
    S_STOP   = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  sh_q, sh_d;
  logic        stop_idx_q, stop_idx_d;
  logic        arm_q, arm_d;
  logic        txd_q, txd_d;
  logic        busy_q, busy_d;
  logic        tx_done_q, tx_done_d;
`ifdef FIFO_UART_TX_PARITY_EN
  logic        par_q, par_d;
`endif

  logic start_ok;
  logic stop_last;
  logic cnt_zero;

  // arm_q is low for the first cycle after reset release, so a FIFO that is
  // already non-empty at release is not popped until the following cycle.
  // rst is included so no pop is requested while reset is being held.
  assign start_ok = (state_q == S_IDLE) && arm_q && rst && tx_en && !fifo_empty;

  // With one stop bit every stop period is the last one.
  assign stop_last = (STOP_BITS == 2) ? stop_idx_q : 1'b1;
  assign cnt_zero  = (cnt_q == 16'd0);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    sh_d       = sh_q;
    stop_idx_d = stop_idx_q;
    arm_d      = 1'b1;
    txd_d      = txd_q;
    busy_d     = busy_q;
    tx_done_d  = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
    par_d      = par_q;
`endif

    // txd_d is derived from the state being entered so that txd_q changes on
    // exactly the edge where the bit period begins.
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          state_d = S_FETCH;
          busy_d  = 1'b1;
        end
      end

      S_FETCH: begin
        // fifo_q is valid now, one cycle after the pop.
        sh_d    = fifo_q;
`ifdef FIFO_UART_TX_PARITY_EN
        par_d   = ^fifo_q;
`endif
        cnt_d   = RELOAD;
        txd_d   = 1'b0;
        state_d = S_START;
      end

      S_START: begin
        if (cnt_zero) begin
          cnt_d   = RELOAD;
          idx_d   = 3'd0;
          txd_d   = sh_q[0];
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end

      S_DATA: begin
        if (cnt_zero) begin
          cnt_d = RELOAD;
          // LSB-first: the bit on the line is always sh_q[0].
          sh_d  = {1'b0, sh_q[7:1]};
          if (idx_q == 3'd7) begin
            idx_d = 3'd0;
`ifdef FIFO_UART_TX_PARITY_EN
            txd_d   = par_q;
            state_d = S_PARITY;
`else
            txd_d      = 1'b1;
            stop_idx_d = 1'b0;
            state_d    = S_STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
            txd_d = sh_q[1];
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end

`ifdef FIFO_UART_TX_PARITY_EN
      S_PARITY: begin
        if (cnt_zero) begin
          cnt_d      = RELOAD;
          txd_d      = 1'b1;
          stop_idx_d = 1'b0;
          state_d    = S_STOP;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
`endif

      S_STOP: begin
        if (cnt_zero) begin
          if (stop_last) begin
            // Back in IDLE next cycle, where a new pop may be issued alongside tx_done.
            cnt_d      = 16'd0;
            stop_idx_d = 1'b0;
            txd_d      = 1'b1;
            busy_d     = 1'b0;
            tx_done_d  = 1'b1;
            state_d    = S_IDLE;
          end else begin
            cnt_d      = RELOAD;
            stop_idx_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end

      default: begin
        cnt_d   = 16'd0;
        txd_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      // An in-flight byte is simply dropped; the line returns high on this edge.
      state_q    <= S_IDLE;
      cnt_q      <= 16'd0;
      idx_q      <= 3'd0;
      sh_q       <= 8'd0;
      stop_idx_q <= 1'b0;
      arm_q      <= 1'b0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      tx_done_q  <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      sh_q       <= sh_d;
      stop_idx_q <= stop_idx_d;
      arm_q      <= arm_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
      tx_done_q  <= tx_done_d;
`ifdef FIFO_UART_TX_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

  // The pop decision depends on this cycle's FIFO flag, so it cannot be registered
  // without adding a cycle to the start latency.
  assign fifo_rdreq = start_ok;
  assign txd        = txd_q;
  assign busy       = busy_q;
  assign tx_done    = tx_done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Purpose : self-checking bench for fifo_uart_tx with a behavioural FIFO and frame-timeline model.
// Latency : expected outputs derived per cycle from the pop times and frame arithmetic.
// Backpressure: FIFO emptiness and tx_en are driven directly by the stimulus sequence.

module tb_fifo_uart_tx;

  localparam int D  = 4;
  localparam int SB = 1;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  // Cycles from first start-bit cycle to first cycle after the last stop bit.
  localparam int F = (10 + SB - 1) * D + (PAR ? D : 0);
  // Pop-to-pop spacing when bytes stream back to back.
  localparam int P = F + 2;
  localparam int TMAX = 1024;

  logic       clk;
  logic       rst;
  logic [7:0] fifo_q;
  logic       fifo_empty;
  logic       fifo_rdreq;
  logic       tx_en;
  logic       txd;
  logic       busy;
  logic       tx_done;

  fifo_uart_tx #(.CLK_DIV(D), .STOP_BITS(SB)) dut (
    .clk       (clk),
    .rst       (rst),
    .fifo_q    (fifo_q),
    .fifo_empty(fifo_empty),
    .fifo_rdreq(fifo_rdreq),
    .tx_en     (tx_en),
    .txd       (txd),
    .busy      (busy),
    .tx_done   (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] fq[$];
  logic [7:0] exp_bytes[$];
  int         exp_rt[$];

  logic tr_txd [TMAX];
  logic tr_rd  [TMAX];
  logic tr_busy[TMAX];
  logic tr_done[TMAX];
  int   tn;

  task automatic chk(input string tag, input logic got, input logic exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  // One clock cycle: sample outputs mid-cycle, then let the FIFO model answer a pop.
  task automatic cyc();
    logic rd;
    @(negedge clk);
    rd = fifo_rdreq;
    if (tn < TMAX) begin
      tr_txd[tn]  = txd;
      tr_rd[tn]   = fifo_rdreq;
      tr_busy[tn] = busy;
      tr_done[tn] = tx_done;
    end
    tn++;
    @(posedge clk);
    #1;
    if (rd) begin
      if (fq.size() > 0) fifo_q = fq.pop_front();
      fifo_empty = (fq.size() == 0);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic push_byte(input logic [7:0] b);
    fq.push_back(b);
    exp_bytes.push_back(b);
    fifo_empty = 1'b0;
  endtask

  // Expected line behaviour: each pop at r gives a frame starting at r+2 of F cycles,
  // tx_done at r+2+F, busy over [r+1, r+F+1]; the line is high everywhere else.
  task automatic check_trace(input string name, input int n);
    for (int c = 0; c < n; c++) begin
      logic e_rd, e_txd, e_busy, e_done;
      e_rd = 1'b0; e_txd = 1'b1; e_busy = 1'b0; e_done = 1'b0;
      for (int k = 0; k < exp_rt.size(); k++) begin
        int r, s, j;
        logic [7:0] bv;
        r  = exp_rt[k];
        s  = r + 2;
        bv = exp_bytes[k];
        if (c == r) e_rd = 1'b1;
        if (c >= r + 1 && c <= r + F + 1) e_busy = 1'b1;
        if (c == s + F) e_done = 1'b1;
        if (c >= s && c < s + F) begin
          j = (c - s) / D;
          if (j == 0)             e_txd = 1'b0;
          else if (j <= 8)        e_txd = bv[j-1];
          else if (PAR && j == 9) e_txd = ^bv;
          else                    e_txd = 1'b1;
        end
      end
      chk($sformatf("%s.txd@%0d", name, c),   tr_txd[c],  e_txd);
      chk($sformatf("%s.rdreq@%0d", name, c), tr_rd[c],   e_rd);
      chk($sformatf("%s.busy@%0d", name, c),  tr_busy[c], e_busy);
      chk($sformatf("%s.done@%0d", name, c),  tr_done[c], e_done);
    end
  endtask

  task automatic new_scenario();
    tn = 0;
    exp_bytes.delete();
    exp_rt.delete();
  endtask

  initial begin
    rst        = 1'b0;
    tx_en      = 1'b1;
    fifo_empty = 1'b1;
    fifo_q     = 8'h00;
    tn         = 0;

    // Reset state with an empty FIFO.
    run(3);
    chk("reset.txd",   tr_txd[2],  1'b1);
    chk("reset.busy",  tr_busy[2], 1'b0);
    chk("reset.done",  tr_done[2], 1'b0);
    chk("reset.rdreq", tr_rd[2],   1'b0);

    // A byte waiting while reset is held must not be popped, nor in the first
    // cycle after release; 0x55 then produces an alternating line.
    new_scenario();
    push_byte(8'h55);
    run(2);
    chk("reset_held.rdreq0", tr_rd[0], 1'b0);
    chk("reset_held.rdreq1", tr_rd[1], 1'b0);
    tn = 0;
    rst = 1'b1;
    exp_rt.push_back(1);
    run(P + 12);
    check_trace("b55", P + 12);

    // Empty FIFO with tx_en high: nothing happens for 100 cycles.
    new_scenario();
    run(100);
    check_trace("empty", 100);

    // Back-to-back stream: directed corner bytes followed by random ones.
    new_scenario();
    push_byte(8'hA3);
    push_byte(8'h0F);
    push_byte(8'h07);
    push_byte(8'h03);
    for (int i = 0; i < 4; i++) push_byte(8'($urandom_range(0, 255)));
    for (int k = 0; k < 8; k++) exp_rt.push_back(k * P);
    run(8 * P + 10);
    check_trace("stream", 8 * P + 10);

    // tx_en dropped during the start bit: current frame completes, the queued byte
    // waits until tx_en returns.
    begin
      int t_en;
      new_scenario();
      t_en = P + 20 + int'($urandom_range(0, 15));
      push_byte(8'h81);
      push_byte(8'($urandom_range(0, 255)));
      run(2);
      tx_en = 1'b0;
      run(t_en - 2);
      tx_en = 1'b1;
      run(P + 10);
      exp_rt.push_back(0);
      exp_rt.push_back(t_en);
      check_trace("txen", t_en + P + 10);
    end

    // Reset during data bit 3 of 0x00 drops the byte and raises the line at once.
    new_scenario();
    push_byte(8'h00);
    exp_rt.push_back(0);
    run(2 + 4 * D + 1);
    check_trace("midrst", 2 + 4 * D + 1);
    chk("midrst.pre_txd", tr_txd[2 + 4 * D], 1'b0);
    rst = 1'b0;
    cyc();
    cyc();
    chk("midrst.txd",   tr_txd[tn-1],  1'b1);
    chk("midrst.busy",  tr_busy[tn-1], 1'b0);
    chk("midrst.done",  tr_done[tn-1], 1'b0);
    chk("midrst.rdreq", tr_rd[tn-1],   1'b0);
    new_scenario();
    rst = 1'b1;
    run(30);
    check_trace("postrst", 30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
